// File: rtl/nvdla_dbb_sram_slave_if.sv
// NVDLA DBB channel bundle (AW, AR, W, B, R) with 4-bit burst length and
// 8-bit transaction ids. The slave modport is the responder view.
interface nvdla_dbb_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [3:0]              aw_len;
  logic [7:0]              aw_id;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [3:0]              ar_len;
  logic [7:0]              ar_id;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [7:0]              b_id;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [7:0]              r_id;
  logic                    r_last;

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_id,
    output aw_ready,
    input  ar_valid, ar_addr, ar_len, ar_id,
    output ar_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id,
    input  b_ready,
    output r_valid, r_data, r_id, r_last,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_addr, aw_len, aw_id,
    input  aw_ready,
    output ar_valid, ar_addr, ar_len, ar_id,
    input  ar_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id,
    output b_ready,
    input  r_valid, r_data, r_id, r_last,
    output r_ready
  );
endinterface

// File: rtl/nvdla_dbb_sram_slave.sv
// DBB responder: services one write or read burst at a time against a
// single-port req/gnt memory with fixed 1-cycle read latency. Read data is
// staged in a 2-entry FIFO so the master can stall R without losing beats.
// Optional feature: define NVDLA_DBB_SRAM_SLAVE_RR_ARB_EN for round-robin
// AR/AW arbitration in IDLE; otherwise reads always win over writes.
module nvdla_dbb_sram_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nvdla_dbb_intf.slave              dbb,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      protocol_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS     = $clog2(BE_WIDTH);

  typedef enum logic [1:0] {IDLE, WR, WRESP, RD} state_e;

  state_e                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_d;
  logic [3:0]                beats_q;
  logic [7:0]                id_q;
  logic [4:0]                reqLeft_q;
  logic                      outstanding_q;
  logic                      protoErr_q;
  logic [DATA_WIDTH-1:0]     fifo_q [2];
  logic                      wrPtr_q;
  logic                      rdPtr_q;
  logic [1:0]                count_q;
  logic [1:0]                count_d;

  logic [ADDR_WIDTH-1:0]     awWord;
  logic [ADDR_WIDTH-1:0]     arWord;
  logic                      unusedWordBits;
  logic                      rdSel;
  logic                      arFire;
  logic                      awFire;
  logic                      wFire;
  logic                      popFire;
  logic                      pushFire;
  logic [1:0]                occupancy;
  logic                      rdIssue;
  logic                      rdGrant;
  logic                      finalBeat;

  // Byte addresses become word addresses; only the low MEM_ADDR_WIDTH bits matter
  assign awWord         = dbb.aw_addr >> OFFS;
  assign arWord         = dbb.ar_addr >> OFFS;
  assign unusedWordBits = ^{awWord, arWord};

`ifdef NVDLA_DBB_SRAM_SLAVE_RR_ARB_EN
  logic lastRead_q;

  // The channel served last yields when both request at once
  assign rdSel = dbb.ar_valid && (!dbb.aw_valid || !lastRead_q);

  // Remember which channel won the most recent IDLE handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastRead_q <= 1'b0;
    end else if (arFire) begin
      lastRead_q <= 1'b1;
    end else if (awFire) begin
      lastRead_q <= 1'b0;
    end
  end
`else
  assign rdSel = dbb.ar_valid;
`endif

  assign finalBeat    = (beats_q == 4'd0);
  assign dbb.ar_ready = (state_q == IDLE) && rdSel;
  assign dbb.aw_ready = (state_q == IDLE) && dbb.aw_valid && !rdSel;
  assign arFire       = dbb.ar_valid && dbb.ar_ready;
  assign awFire       = dbb.aw_valid && dbb.aw_ready;

  assign dbb.w_ready  = (state_q == WR) && mem_gnt;
  assign wFire        = dbb.w_valid && dbb.w_ready;

  assign dbb.b_valid  = (state_q == WRESP);
  assign dbb.b_id     = id_q;

  assign dbb.r_valid  = (count_q != 2'd0);
  assign dbb.r_data   = fifo_q[rdPtr_q];
  assign dbb.r_id     = id_q;
  assign dbb.r_last   = dbb.r_valid && finalBeat;
  assign popFire      = dbb.r_valid && dbb.r_ready;
  assign pushFire     = mem_rvalid && (state_q == RD);

  assign occupancy    = {1'b0, outstanding_q} + count_q;
  assign rdIssue      = (state_q == RD) && (reqLeft_q != 5'd0) && (occupancy < 2'd2);
  assign rdGrant      = rdIssue && mem_gnt;

  assign addr_d       = addr_q + 1'b1;
  assign protocol_err = protoErr_q;

  // Memory port follows W directly in WR and the read issuer in RD
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      WR: begin
        mem_req   = dbb.w_valid;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_be    = dbb.w_strb;
        mem_wdata = dbb.w_data;
      end
      RD: begin
        mem_req   = rdIssue;
        mem_addr  = addr_q;
        mem_be    = '1;
      end
      default: ;
    endcase
  end

  // Burst sequencing; beats_q counts down to the final beat of either direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      id_q       <= '0;
      reqLeft_q  <= '0;
      protoErr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arFire) begin
            addr_q    <= arWord[MEM_ADDR_WIDTH-1:0];
            beats_q   <= dbb.ar_len;
            id_q      <= dbb.ar_id;
            reqLeft_q <= {1'b0, dbb.ar_len} + 5'd1;
            state_q   <= RD;
          end else if (awFire) begin
            addr_q    <= awWord[MEM_ADDR_WIDTH-1:0];
            beats_q   <= dbb.aw_len;
            id_q      <= dbb.aw_id;
            state_q   <= WR;
          end
        end
        WR: begin
          if (wFire) begin
            addr_q <= addr_d;
            if (dbb.w_last != finalBeat) begin
              protoErr_q <= 1'b1;
            end
            if (finalBeat) begin
              state_q <= WRESP;
            end else begin
              beats_q <= beats_q - 4'd1;
            end
          end
        end
        WRESP: begin
          if (dbb.b_ready) begin
            state_q <= IDLE;
          end
        end
        RD: begin
          if (rdGrant) begin
            addr_q    <= addr_d;
            reqLeft_q <= reqLeft_q - 5'd1;
          end
          if (popFire) begin
            if (finalBeat) begin
              state_q <= IDLE;
            end else begin
              beats_q <= beats_q - 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Track the single in-flight read between grant and its data return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= 1'b0;
    end else if (rdGrant) begin
      outstanding_q <= 1'b1;
    end else if (mem_rvalid) begin
      outstanding_q <= 1'b0;
    end
  end

  // Occupancy moves only when exactly one of push/pop happens
  always_comb begin
    count_d = count_q;
    if (pushFire && !popFire) begin
      count_d = count_q + 2'd1;
    end else if (popFire && !pushFire) begin
      count_d = count_q - 2'd1;
    end
  end

  // Two-entry read data FIFO, flushed by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (pushFire) begin
        fifo_q[wrPtr_q] <= mem_rdata;
        wrPtr_q         <= ~wrPtr_q;
      end
      if (popFire) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_nvdla_dbb_sram_slave.sv
// Directed bench for nvdla_dbb_sram_slave: arbitration, single write,
// 16-beat read with R back-pressure, address wrap, protocol error with
// grant stall, and reset in the middle of a read burst.
module tb_nvdla_dbb_sram_slave;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 16;

  logic          clk;
  logic          rst_n;
  logic          mem_req;
  logic          memGnt;
  logic          mem_we;
  logic [MW-1:0] mem_addr;
  logic [7:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          memRvalid;
  logic [DW-1:0] memRdata;
  logic          protocol_err;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] wrAddrQ [$];
  logic [63:0] wrDataQ [$];
  logic [15:0] rdAddrQ [$];

  nvdla_dbb_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbbIf ();

  nvdla_dbb_sram_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dbb(dbbIf.slave),
    .mem_req(mem_req),
    .mem_gnt(memGnt),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_rvalid(memRvalid),
    .mem_rdata(memRdata),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed function of the word address
  function automatic logic [63:0] memWord(input logic [15:0] a);
    return {16'hBEEF, a, 16'h5A5A, ~a};
  endfunction

  // Memory model: 1-cycle read latency, logs every granted access
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memRvalid <= 1'b0;
      memRdata  <= '0;
    end else begin
      memRvalid <= mem_req && memGnt && !mem_we;
      memRdata  <= memWord(mem_addr);
      if (mem_req && memGnt && mem_we) begin
        wrAddrQ.push_back(mem_addr);
        wrDataQ.push_back(mem_wdata);
      end
      if (mem_req && memGnt && !mem_we) begin
        rdAddrQ.push_back(mem_addr);
      end
    end
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one AR or AW request and waits (bounded) for its handshake
  task automatic applyStimulus(input bit isRead, input logic [31:0] addr, input logic [3:0] len,
                               input logic [7:0] id, input string tag);
    bit done = 1'b0;
    bit rdy;
    if (isRead) begin
      dbbIf.ar_valid = 1'b1; dbbIf.ar_addr = addr; dbbIf.ar_len = len; dbbIf.ar_id = id;
    end else begin
      dbbIf.aw_valid = 1'b1; dbbIf.aw_addr = addr; dbbIf.aw_len = len; dbbIf.aw_id = id;
    end
    for (int k = 0; k < 50; k++) begin
      #1;
      rdy = isRead ? dbbIf.ar_ready : dbbIf.aw_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    dbbIf.ar_valid = 1'b0;
    dbbIf.aw_valid = 1'b0;
    checkOutput({tag, "_handshake"}, done, 1'b1);
  endtask

  // Drains a read burst, checking data order, r_last, r_id and first-beat latency
  task automatic readBurst(input logic [15:0] startWord, input int len, input logic [7:0] id,
                           input bit toggle, input string tag);
    int popped = 0;
    int firstValid = -1;
    logic [15:0] w = startWord;
    for (int k = 0; k < 400 && popped <= len; k++) begin
      dbbIf.r_ready = toggle ? k[0] : 1'b1;
      #1;
      if (k == 0) checkOutput({tag, "_req_latency"}, mem_req, 1'b1);
      if (dbbIf.r_valid && firstValid < 0) firstValid = k;
      if (dbbIf.r_valid && dbbIf.r_ready) begin
        checkOutput({tag, "_data"}, dbbIf.r_data, memWord(w));
        checkOutput({tag, "_last"}, dbbIf.r_last, (popped == len));
        checkOutput({tag, "_rid"}, dbbIf.r_id, id);
        w = w + 16'd1;
        popped++;
      end
      @(posedge clk);
      #1;
    end
    dbbIf.r_ready = 1'b0;
    checkOutput({tag, "_beats"}, popped, len + 1);
    checkOutput({tag, "_first_valid_cycle"}, firstValid, 2);
    #1;
    checkOutput({tag, "_rvalid_after"}, dbbIf.r_valid, 1'b0);
  endtask

  // Sends a full W burst with correct w_last, then takes the B response
  task automatic writeBurst(input logic [15:0] startWord, input int len, input logic [7:0] id,
                            input logic [63:0] dataBase, input string tag);
    bit fired;
    wrAddrQ.delete();
    wrDataQ.delete();
    for (int b = 0; b <= len; b++) begin
      dbbIf.w_valid = 1'b1;
      dbbIf.w_data  = dataBase + 64'(b);
      dbbIf.w_strb  = 8'hFF;
      dbbIf.w_last  = (b == len);
      fired = 1'b0;
      for (int k = 0; k < 50; k++) begin
        #1;
        fired = dbbIf.w_ready;
        @(posedge clk);
        #1;
        if (fired) break;
      end
      checkOutput({tag, "_wbeat"}, fired, 1'b1);
    end
    dbbIf.w_valid = 1'b0;
    dbbIf.w_last  = 1'b0;
    #1;
    checkOutput({tag, "_bvalid"}, dbbIf.b_valid, 1'b1);
    checkOutput({tag, "_bid"}, dbbIf.b_id, id);
    dbbIf.b_ready = 1'b1;
    tick();
    dbbIf.b_ready = 1'b0;
    checkOutput({tag, "_wr_count"}, wrAddrQ.size(), len + 1);
    for (int b = 0; b <= len && b < wrAddrQ.size(); b++) begin
      checkOutput({tag, "_wr_addr"}, wrAddrQ[b], startWord + 16'(b));
      checkOutput({tag, "_wr_data"}, wrDataQ[b], dataBase + 64'(b));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit expRead;
    int popped;
    rst_n = 1'b0;
    memGnt = 1'b1;
    dbbIf.aw_valid = 1'b0; dbbIf.aw_addr = '0; dbbIf.aw_len = '0; dbbIf.aw_id = '0;
    dbbIf.ar_valid = 1'b0; dbbIf.ar_addr = '0; dbbIf.ar_len = '0; dbbIf.ar_id = '0;
    dbbIf.w_valid = 1'b0; dbbIf.w_data = '0; dbbIf.w_strb = '0; dbbIf.w_last = 1'b0;
    dbbIf.b_ready = 1'b0; dbbIf.r_ready = 1'b0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_aw_ready", dbbIf.aw_ready, 1'b0);
    checkOutput("rst_ar_ready", dbbIf.ar_ready, 1'b0);
    checkOutput("rst_w_ready", dbbIf.w_ready, 1'b0);
    checkOutput("rst_b_valid", dbbIf.b_valid, 1'b0);
    checkOutput("rst_r_valid", dbbIf.r_valid, 1'b0);
    checkOutput("rst_r_last", dbbIf.r_last, 1'b0);
    checkOutput("rst_b_id", dbbIf.b_id, 8'h00);
    checkOutput("rst_r_id", dbbIf.r_id, 8'h00);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0);
    checkOutput("rst_mem_be", mem_be, 8'h00);
    checkOutput("rst_mem_wdata", mem_wdata, 64'h0);
    checkOutput("rst_protocol_err", protocol_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---- simultaneous AW and AR, twice ----
    for (int r = 0; r < 2; r++) begin
      dbbIf.aw_valid = 1'b1; dbbIf.aw_addr = 32'h200; dbbIf.aw_len = 4'd0; dbbIf.aw_id = 8'h0A;
      dbbIf.ar_valid = 1'b1; dbbIf.ar_addr = 32'h300; dbbIf.ar_len = 4'd0; dbbIf.ar_id = 8'h0B;
`ifdef NVDLA_DBB_SRAM_SLAVE_RR_ARB_EN
      expRead = (r == 0);
`else
      expRead = 1'b1;
`endif
      #1;
      checkOutput("arb_ar_ready", dbbIf.ar_ready, expRead);
      checkOutput("arb_aw_ready", dbbIf.aw_ready, !expRead);
      tick();
      dbbIf.aw_valid = 1'b0;
      dbbIf.ar_valid = 1'b0;
      if (expRead) readBurst(16'h0060, 0, 8'h0B, 1'b0, "arb_rd");
      else         writeBurst(16'h0040, 0, 8'h0A, 64'h1111_2222_3333_4444, "arb_wr");
      tick();
    end

    // ---- single write, W presented before AW ----
    wrAddrQ.delete();
    wrDataQ.delete();
    dbbIf.aw_valid = 1'b1; dbbIf.aw_addr = 32'h100; dbbIf.aw_len = 4'd0; dbbIf.aw_id = 8'h12;
    dbbIf.w_valid = 1'b1; dbbIf.w_data = 64'hDEADBEEF_CAFEF00D; dbbIf.w_strb = 8'hFF; dbbIf.w_last = 1'b1;
    #1;
    checkOutput("wr1_aw_ready", dbbIf.aw_ready, 1'b1);
    checkOutput("wr1_w_held_off", dbbIf.w_ready, 1'b0);
    tick();
    dbbIf.aw_valid = 1'b0;
    #1;
    checkOutput("wr1_w_ready", dbbIf.w_ready, 1'b1);
    checkOutput("wr1_mem_req", mem_req, 1'b1);
    checkOutput("wr1_mem_we", mem_we, 1'b1);
    checkOutput("wr1_mem_addr", mem_addr, 16'h0020);
    checkOutput("wr1_mem_be", mem_be, 8'hFF);
    checkOutput("wr1_mem_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
    tick();
    dbbIf.w_valid = 1'b0;
    dbbIf.w_last = 1'b0;
    #1;
    checkOutput("wr1_b_valid", dbbIf.b_valid, 1'b1);
    checkOutput("wr1_b_id", dbbIf.b_id, 8'h12);
    checkOutput("wr1_log_count", wrAddrQ.size(), 1);
    if (wrAddrQ.size() > 0) begin
      checkOutput("wr1_log_addr", wrAddrQ[0], 16'h0020);
      checkOutput("wr1_log_data", wrDataQ[0], 64'hDEADBEEF_CAFEF00D);
    end
    checkOutput("wr1_protocol_err", protocol_err, 1'b0);
    dbbIf.b_ready = 1'b1;
    tick();
    dbbIf.b_ready = 1'b0;
    #1;
    checkOutput("wr1_b_done", dbbIf.b_valid, 1'b0);
    tick();

    // ---- 16-beat read with r_ready toggling ----
    applyStimulus(1'b1, 32'h0, 4'd15, 8'h03, "rd16");
    readBurst(16'h0000, 15, 8'h03, 1'b1, "rd16");
    tick();

    // ---- address wrap ----
    rdAddrQ.delete();
    applyStimulus(1'b1, 32'h0007_FFF0, 4'd3, 8'h07, "wrap");
    readBurst(16'hFFFE, 3, 8'h07, 1'b0, "wrap");
    checkOutput("wrap_req_count", rdAddrQ.size(), 4);
    if (rdAddrQ.size() == 4) begin
      checkOutput("wrap_addr0", rdAddrQ[0], 16'hFFFE);
      checkOutput("wrap_addr1", rdAddrQ[1], 16'hFFFF);
      checkOutput("wrap_addr2", rdAddrQ[2], 16'h0000);
      checkOutput("wrap_addr3", rdAddrQ[3], 16'h0001);
    end
    tick();

    // ---- protocol error plus grant stall ----
    wrAddrQ.delete();
    wrDataQ.delete();
    applyStimulus(1'b0, 32'h800, 4'd1, 8'h21, "perr");
    dbbIf.w_valid = 1'b1; dbbIf.w_data = 64'hAAAA_0000_0000_0001; dbbIf.w_strb = 8'hFF; dbbIf.w_last = 1'b1;
    #1;
    checkOutput("perr_beat0_ready", dbbIf.w_ready, 1'b1);
    tick();
    memGnt = 1'b0;
    dbbIf.w_data = 64'hAAAA_0000_0000_0002;
    dbbIf.w_last = 1'b1;
    #1;
    checkOutput("perr_set", protocol_err, 1'b1);
    for (int s = 0; s < 3; s++) begin
      checkOutput("stall_w_ready", dbbIf.w_ready, 1'b0);
      checkOutput("stall_mem_req", mem_req, 1'b1);
      checkOutput("stall_mem_addr", mem_addr, 16'h0101);
      tick();
      #1;
    end
    memGnt = 1'b1;
    #1;
    checkOutput("perr_beat1_ready", dbbIf.w_ready, 1'b1);
    tick();
    dbbIf.w_valid = 1'b0;
    dbbIf.w_last = 1'b0;
    #1;
    checkOutput("perr_b_valid", dbbIf.b_valid, 1'b1);
    checkOutput("perr_b_id", dbbIf.b_id, 8'h21);
    dbbIf.b_ready = 1'b1;
    tick();
    dbbIf.b_ready = 1'b0;
    #1;
    checkOutput("perr_sticky", protocol_err, 1'b1);
    checkOutput("perr_wr_count", wrAddrQ.size(), 2);
    if (wrAddrQ.size() == 2) begin
      checkOutput("perr_wr_addr0", wrAddrQ[0], 16'h0100);
      checkOutput("perr_wr_addr1", wrAddrQ[1], 16'h0101);
      checkOutput("perr_wr_data1", wrDataQ[1], 64'hAAAA_0000_0000_0002);
    end
    tick();

    // ---- reset during beat 5 of an 8-beat read ----
    applyStimulus(1'b1, 32'h180, 4'd7, 8'h44, "rstmid");
    dbbIf.r_ready = 1'b1;
    popped = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (dbbIf.r_valid) begin
        if (popped == 5) break;
        popped++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("rstmid_reached_beat5", popped, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_r_valid", dbbIf.r_valid, 1'b0);
    checkOutput("rstmid_r_last", dbbIf.r_last, 1'b0);
    checkOutput("rstmid_r_id", dbbIf.r_id, 8'h00);
    checkOutput("rstmid_mem_req", mem_req, 1'b0);
    checkOutput("rstmid_mem_addr", mem_addr, 16'h0);
    checkOutput("rstmid_mem_be", mem_be, 8'h00);
    checkOutput("rstmid_protocol_err", protocol_err, 1'b0);
    dbbIf.r_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h280, 4'd1, 8'h55, "postrst");
    readBurst(16'h0050, 1, 8'h55, 1'b0, "postrst");
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
